// File: rtl/pc_register.sv
// Program-counter register: loads word-aligned pcNext when en is high and flags misaligned targets.
// Latency 1 cycle pcNext->pc; pcPlus4 is combinational. en=0 stalls (pc holds) and there is no other backpressure.
// Optional PC_TRACE_EN adds pcPrev/loadCount trace outputs.
module pc_register #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned ALIGN_BITS   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] pcNext,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic        misaligned
`ifdef PC_TRACE_EN
  ,
  output logic [31:0] pcPrev,
  output logic [15:0] loadCount
`endif
);

  // With ALIGN_BITS=0 the mask is empty, so loads pass through unmasked and misaligned stays 0.
  localparam logic [31:0] LOW_MASK = (32'd1 << ALIGN_BITS) - 32'd1;

  logic [31:0] pc_aligned;
  logic        low_set;

  always_comb begin
    pc_aligned = pcNext & ~LOW_MASK;
    low_set    = |(pcNext & LOW_MASK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_VECTOR;
      misaligned <= 1'b0;
    end else if (en) begin
      pc         <= pc_aligned;
      misaligned <= low_set;
    end else begin
      misaligned <= 1'b0;
    end
  end

  assign pcPlus4 = pc + 32'd4;

`ifdef PC_TRACE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcPrev    <= RESET_VECTOR;
      loadCount <= 16'd0;
    end else if (en) begin
      pcPrev    <= pc;
      loadCount <= loadCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_register.sv
// Self-checking bench for pc_register: arithmetic reference model compared every cycle plus literal checkpoints.
module tb_pc_register;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] pcNext;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        misaligned;
`ifdef PC_TRACE_EN
  logic [31:0] pcPrev;
  logic [15:0] loadCount;
`endif

  int checks   = 0;
  int failures = 0;
  bit run      = 1'b0;

  pc_register #(.RESET_VECTOR(32'h0), .ALIGN_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pcNext(pcNext),
    .pc(pc), .pcPlus4(pcPlus4), .misaligned(misaligned)
`ifdef PC_TRACE_EN
    , .pcPrev(pcPrev), .loadCount(loadCount)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: word-aligned target is floor(pcNext/4)*4, misaligned iff pcNext mod 4 != 0.
  longint unsigned m_pc, m_prev, m_cnt;
  bit m_mis;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 0; m_prev = 0; m_cnt = 0; m_mis = 0;
    end else if (en === 1'b1) begin
      m_prev = m_pc;
      m_pc   = (longint'(pcNext) / 4) * 4;
      m_mis  = (longint'(pcNext) % 4) != 0;
      m_cnt  = (m_cnt + 1) % 65536;
    end else begin
      m_mis = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("model_pc", pc, 32'(m_pc));
      chk("model_pcPlus4", pcPlus4, 32'((m_pc + 4) % 64'h1_0000_0000));
      chk("model_misaligned", {31'd0, misaligned}, {31'd0, m_mis});
`ifdef PC_TRACE_EN
      chk("model_pcPrev", pcPrev, 32'(m_prev));
      chk("model_loadCount", {16'd0, loadCount}, 32'(m_cnt));
`endif
    end
  end

  // Apply inputs, take one rising edge, then settle 1 time unit past it.
  task automatic step(input logic e, input logic [31:0] v);
    en = e; pcNext = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; pcNext = 32'h0;
    #1;
    run = 1'b1;
    chk("reset_pc", pc, 32'h0);
    chk("reset_pcPlus4", pcPlus4, 32'h4);
    chk("reset_mis", {31'd0, misaligned}, 32'd0);
    step(1'b1, 32'h10);
    chk("held_in_reset", pc, 32'h0);
    #2 rst_n = 1'b1;

    step(1'b1, 32'h10);
    chk("load1_pc", pc, 32'h10);
    chk("load1_pcPlus4", pcPlus4, 32'h14);
    step(1'b0, 32'h40);
    chk("stall_between", pc, 32'h10);
    step(1'b1, 32'h20);
    chk("load2_pc", pc, 32'h20);
    chk("load2_pcPlus4", pcPlus4, 32'h24);
    chk("load2_mis", {31'd0, misaligned}, 32'd0);
`ifdef PC_TRACE_EN
    chk("trace_prev", pcPrev, 32'h10);
    chk("trace_count", {16'd0, loadCount}, 32'd2);
`endif
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h40);
      chk("stall_pc", pc, 32'h20);
    end
    step(1'b0, 32'hxxxx_xxxx);
    chk("stall_x_pc", pc, 32'h20);
    step(1'b1, 32'h40);
    chk("resume_pc", pc, 32'h40);

    // Asynchronous reset mid-cycle, no clock edge in between.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_pcPlus4", pcPlus4, 32'h4);
    chk("async_rst_mis", {31'd0, misaligned}, 32'd0);
    #1 rst_n = 1'b1;
    step(1'b1, 32'h80);
    chk("post_rst_load", pc, 32'h80);

    // Reset asserted on the same edge as an enabled load: reset wins.
    en = 1'b1; pcNext = 32'h1234;
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_vs_edge_pc", pc, 32'h0);
    #3 rst_n = 1'b1;

    step(1'b1, 32'h0000_00FF);
    chk("mis1_pc", pc, 32'h0000_00FC);
    chk("mis1_flag", {31'd0, misaligned}, 32'd1);
    step(1'b1, 32'h0000_FFFF);
    chk("mis2_pc", pc, 32'h0000_FFFC);
    chk("mis2_flag", {31'd0, misaligned}, 32'd1);
    step(1'b1, 32'h0000_0100);
    chk("mis3_flag", {31'd0, misaligned}, 32'd0);
    step(1'b1, 32'h0000_0202);
    chk("mis4_pc", pc, 32'h0000_0200);
    step(1'b0, 32'h0000_0303);
    chk("mis_not_sticky", {31'd0, misaligned}, 32'd0);

    step(1'b1, 32'hFFFF_FFFC);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pcPlus4", pcPlus4, 32'h0000_0000);
    step(1'b1, 32'hFFFF_FFFF);
    chk("wrap_mis_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_mis_flag", {31'd0, misaligned}, 32'd1);

    for (int i = 0; i < 8; i++) step(1'b1, 32'h1000 + 32'(i) * 4 + 32'(i % 4));
    step(1'b0, 32'h0);
    @(negedge clk);
    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
